// File: rtl/sync_fifo_buf_if.sv
// sync_fifo_buf_if: request/response bundle between a single-clock FIFO and
// the logic that shares its clock. The master modport is the producer/consumer
// side; the slave modport is the FIFO itself. clk and rst are not part of the
// bundle and stay plain ports on the FIFO.
interface sync_fifo_buf_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 9
);
    // Write side
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] data_write;

    // Read side
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] data_read;
    logic                  rvalid;

    // Status
    logic                  wfull;
    logic                  rempty;
    logic                  walmost_full;
    logic                  ralmost_empty;
    logic [PTR_WIDTH:0]    count;

    // Sticky error reporting
    logic                  err_clear;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_enable, data_write, read_enable, err_clear,
        input  data_read, rvalid, wfull, rempty, walmost_full, ralmost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  write_enable, data_write, read_enable, err_clear,
        output data_read, rvalid, wfull, rempty, walmost_full, ralmost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_buf.sv
// sync_fifo_buf: single-clock FIFO with a registered read port, occupancy
// count, full/empty and programmable almost-full/almost-empty flags.
// Optional sticky overflow/underflow flags are built when the macro
// SYNC_FIFO_BUF_ERR_FLAGS_EN is defined; otherwise those outputs are tied
// low and err_clear is ignored.
// DEPTH must equal 2**PTR_WIDTH. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without consulting the count.
module sync_fifo_buf #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 512,
    parameter int PTR_WIDTH     = 9,
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic          clk,
    input  logic          rst,
    sync_fifo_buf_if.slave bus
);

    localparam logic [PTR_WIDTH:0] LP_AFULL  = (PTR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [PTR_WIDTH:0] LP_AEMPTY = (PTR_WIDTH+1)'(AEMPTY_THRESH);

    // Storage (not reset) and control state
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH:0]    r_wptr;
    logic [PTR_WIDTH:0]    r_rptr;
    logic [PTR_WIDTH:0]    r_count;
    logic [DATA_WIDTH-1:0] r_data_read;
    logic                  r_rvalid;

    // Decoded status and handshake qualifiers
    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_ovf_evt;
    logic w_unf_evt;

    // Full when the wrap bits differ and the addresses match; empty when the
    // pointers are identical. Both come straight from registered pointers.
    assign w_full  = (r_wptr[PTR_WIDTH] != r_rptr[PTR_WIDTH]) &&
                     (r_wptr[PTR_WIDTH-1:0] == r_rptr[PTR_WIDTH-1:0]);
    assign w_empty = (r_wptr == r_rptr);

    // A full FIFO still accepts a read and an empty one still accepts a
    // write, so simultaneous requests at either boundary resolve naturally.
    assign w_wr_acc = bus.write_enable && !w_full;
    assign w_rd_acc = bus.read_enable  && !w_empty;

    assign w_ovf_evt = bus.write_enable && w_full;
    assign w_unf_evt = bus.read_enable  && w_empty;

    // Write port: store accepted data at the current write address
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr[PTR_WIDTH-1:0]] <= bus.data_write;
        end
    end

    // Write pointer advances once per accepted write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (w_wr_acc) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    // Read pointer advances once per accepted read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr <= '0;
        end else if (w_rd_acc) begin
            r_rptr <= r_rptr + 1'b1;
        end
    end

    // Occupancy: +1 write only, -1 read only, unchanged for both or neither
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered read port: data loads only on an accepted read and holds
    // otherwise, so a consumer can sample it any time after rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_read <= '0;
        end else if (w_rd_acc) begin
            r_data_read <= r_mem[r_rptr[PTR_WIDTH-1:0]];
        end
    end

    // rvalid marks the single cycle after an accepted read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_acc;
        end
    end

`ifdef SYNC_FIFO_BUF_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky overflow: a new event wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_evt) begin
            r_overflow <= 1'b1;
        end else if (bus.err_clear) begin
            r_overflow <= 1'b0;
        end
    end

    // Sticky underflow: a new event wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (w_unf_evt) begin
            r_underflow <= 1'b1;
        end else if (bus.err_clear) begin
            r_underflow <= 1'b0;
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    // Error reporting compiled out: outputs tied low, inputs deliberately sunk
    logic w_err_unused;
    assign w_err_unused  = bus.err_clear ^ w_ovf_evt ^ w_unf_evt;
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    // Output mapping; threshold flags decode from the registered count
    assign bus.data_read     = r_data_read;
    assign bus.rvalid        = r_rvalid;
    assign bus.wfull         = w_full;
    assign bus.rempty        = w_empty;
    assign bus.count         = r_count;
    assign bus.walmost_full  = (r_count >= LP_AFULL);
    assign bus.ralmost_empty = (r_count <= LP_AEMPTY);

endmodule

// File: tb/tb_sync_fifo_buf.sv
// tb_sync_fifo_buf: directed-vector bench for sync_fifo_buf at DEPTH=8.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point after the following edge.
module tb_sync_fifo_buf;

    localparam int DW = 8;
    localparam int PW = 3;
`ifdef SYNC_FIFO_BUF_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    sync_fifo_buf_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) u_if ();

    sync_fifo_buf #(
        .DATA_WIDTH   (DW),
        .DEPTH        (8),
        .PTR_WIDTH    (PW),
        .AFULL_THRESH (6),
        .AEMPTY_THRESH(2)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [7:0] d, input logic re, input logic ec);
        u_if.write_enable = we;
        u_if.data_write   = d;
        u_if.read_enable  = re;
        u_if.err_clear    = ec;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(u_if.count), 0);
        chk({tag, "_rempty"}, 32'(u_if.rempty), 1);
        chk({tag, "_wfull"}, 32'(u_if.wfull), 0);
        chk({tag, "_aempty"}, 32'(u_if.ralmost_empty), 1);
        chk({tag, "_afull"}, 32'(u_if.walmost_full), 0);
        chk({tag, "_dread"}, 32'(u_if.data_read), 0);
        chk({tag, "_rvalid"}, 32'(u_if.rvalid), 0);
        chk({tag, "_ovf"}, 32'(u_if.overflow), 0);
        chk({tag, "_unf"}, 32'(u_if.underflow), 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        drive(0, 8'h00, 0, 0);
        step();
        step();
        chk_reset_state("rst0");
        rst = 1'b0;

        // Fill 0x10..0x17 with flag tracking
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'(8'h10 + i), 0, 0);
            step();
            chk("fill_count", 32'(u_if.count), 32'(i + 1));
            chk("fill_afull", 32'(u_if.walmost_full), 32'((i + 1) >= 6));
            chk("fill_aempty", 32'(u_if.ralmost_empty), 32'((i + 1) <= 2));
            chk("fill_wfull", 32'(u_if.wfull), 32'(i == 7));
            chk("fill_rempty", 32'(u_if.rempty), 0);
        end

        // Drain: data appears with rvalid one cycle after each read
        for (int i = 0; i < 8; i++) begin
            drive(0, 8'h00, 1, 0);
            step();
            chk("drain_rvalid", 32'(u_if.rvalid), 1);
            chk("drain_data", 32'(u_if.data_read), 32'(8'h10 + i));
            chk("drain_count", 32'(u_if.count), 32'(7 - i));
            chk("drain_wfull", 32'(u_if.wfull), 0);
        end
        drive(0, 8'h00, 0, 0);
        step();
        chk("drain_rvalid_end", 32'(u_if.rvalid), 0);
        chk("drain_hold", 32'(u_if.data_read), 32'h17);
        chk("drain_rempty", 32'(u_if.rempty), 1);

        // Wrap-around: three rounds of write 5 / read 5
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) begin
                drive(1, 8'(8'h30 + 16 * r + k), 0, 0);
                step();
                chk("wrap_wfull", 32'(u_if.wfull), 0);
                chk("wrap_rempty", 32'(u_if.rempty), 0);
            end
            for (int k = 0; k < 5; k++) begin
                drive(0, 8'h00, 1, 0);
                step();
                chk("wrap_data", 32'(u_if.data_read), 32'(8'h30 + 16 * r + k));
                chk("wrap_rvalid", 32'(u_if.rvalid), 1);
            end
            drive(0, 8'h00, 0, 0);
            chk("wrap_count0", 32'(u_if.count), 0);
            chk("wrap_empty", 32'(u_if.rempty), 1);
        end

        // Simultaneous read+write while empty: write wins, read rejected
        drive(1, 8'hA5, 1, 0);
        step();
        chk("sim_empty_count", 32'(u_if.count), 1);
        chk("sim_empty_rvalid", 32'(u_if.rvalid), 0);
        chk("sim_empty_unf", 32'(u_if.underflow), 32'(ERR_EN));
        drive(0, 8'h00, 0, 1);
        step();
        chk("clr1_unf", 32'(u_if.underflow), 0);

        // Bring count to 4, then simultaneous read+write keeps it at 4
        for (int k = 0; k < 3; k++) begin
            drive(1, 8'(8'hA6 + k), 0, 0);
            step();
        end
        chk("mid_count", 32'(u_if.count), 4);
        drive(1, 8'hA9, 1, 0);
        step();
        chk("sim_mid_count", 32'(u_if.count), 4);
        chk("sim_mid_data", 32'(u_if.data_read), 32'hA5);
        chk("sim_mid_rvalid", 32'(u_if.rvalid), 1);

        // Fill to full, then simultaneous request: read accepted, write dropped
        for (int k = 0; k < 4; k++) begin
            drive(1, 8'(8'hB0 + k), 0, 0);
            step();
        end
        chk("full_wfull", 32'(u_if.wfull), 1);
        drive(1, 8'hEE, 1, 0);
        step();
        chk("sim_full_count", 32'(u_if.count), 7);
        chk("sim_full_data", 32'(u_if.data_read), 32'hA6);
        chk("sim_full_wfull", 32'(u_if.wfull), 0);
        chk("sim_full_ovf", 32'(u_if.overflow), 32'(ERR_EN));
        begin
            logic [7:0] exp_q [7];
            exp_q = '{8'hA7, 8'hA8, 8'hA9, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
            for (int k = 0; k < 7; k++) begin
                drive(0, 8'h00, 1, 0);
                step();
                chk("sim_full_drain", 32'(u_if.data_read), 32'(exp_q[k]));
            end
        end
        drive(0, 8'h00, 0, 1);
        step();
        chk("drop_empty", 32'(u_if.rempty), 1);
        chk("clr2_ovf", 32'(u_if.overflow), 0);

        // Error flags: write while full, hold, read while empty, clear
        for (int k = 0; k < 8; k++) begin
            drive(1, 8'(8'hC0 + k), 0, 0);
            step();
        end
        drive(1, 8'hFF, 0, 0);
        step();
        chk("ovf_set", 32'(u_if.overflow), 32'(ERR_EN));
        chk("ovf_count", 32'(u_if.count), 8);
        drive(0, 8'h00, 0, 0);
        step();
        step();
        chk("ovf_hold", 32'(u_if.overflow), 32'(ERR_EN));
        for (int k = 0; k < 8; k++) begin
            drive(0, 8'h00, 1, 0);
            step();
            chk("err_drain", 32'(u_if.data_read), 32'(8'hC0 + k));
        end
        drive(0, 8'h00, 1, 0);
        step();
        chk("unf_set", 32'(u_if.underflow), 32'(ERR_EN));
        chk("unf_rvalid", 32'(u_if.rvalid), 0);
        chk("unf_count", 32'(u_if.count), 0);
        drive(0, 8'h00, 1, 1);
        step();
        chk("clr_vs_evt_unf", 32'(u_if.underflow), 32'(ERR_EN));
        chk("clr_vs_evt_ovf", 32'(u_if.overflow), 0);
        drive(0, 8'h00, 0, 1);
        step();
        chk("clr_unf", 32'(u_if.underflow), 0);
        chk("clr_ovf", 32'(u_if.overflow), 0);
        drive(0, 8'h00, 0, 0);

        // Mid-stream asynchronous reset with count=5 and rvalid high
        for (int k = 0; k < 6; k++) begin
            drive(1, 8'(8'h60 + k), 0, 0);
            step();
        end
        drive(0, 8'h00, 1, 0);
        step();
        drive(0, 8'h00, 0, 0);
        chk("pre_rst_count", 32'(u_if.count), 5);
        chk("pre_rst_rvalid", 32'(u_if.rvalid), 1);
        chk("pre_rst_data", 32'(u_if.data_read), 32'h60);
        #1 rst = 1'b1;
        #1;
        chk_reset_state("rst_mid");
        step();
        rst = 1'b0;

        // Recovery after reset
        drive(1, 8'h55, 0, 0);
        step();
        chk("post_rst_count", 32'(u_if.count), 1);
        drive(0, 8'h00, 1, 0);
        step();
        chk("post_rst_data", 32'(u_if.data_read), 32'h55);
        chk("post_rst_rvalid", 32'(u_if.rvalid), 1);
        drive(0, 8'h00, 0, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
